// File: rtl/imem_burst_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imem_burst_loader
//
// Copies a program image into the instruction memory. Words are read from
// HPS/SDRAM with Avalon-MM burst reads and written through the imem write port.
// The core is held in reset for as long as a load is in progress. Only one
// burst is outstanding at a time, and a burst is never longer than MAX_BURST
// words.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to keep a 32-bit running sum
// of the written words. Without it, checksum is tied to zero.
//
// Ports
//   clk, reset_n          system clock; synchronous active-low reset
//   start, abort          one-cycle control pulses from the CSR block
//   src_addr              byte source address (bits [1:0] ignored)
//   dst_waddr             first imem word address (wraps modulo 2^MEM_ADDR_WIDTH)
//   word_count            number of 32-bit words to copy (0 is legal)
//   busy, core_hold       high from the cycle after an accepted start until done
//   done                  one-cycle completion pulse
//   aborted               sticky abort status, cleared by the next start
//   avm_*                 Avalon-MM burst read master
//   mem_write/waddr/wdata/be  imem write port
//   checksum              sum of the written words (zero when the feature is off)
// -----------------------------------------------------------------------------
module imem_burst_loader #(
   parameter int unsigned MEM_ADDR_WIDTH = 12,
   parameter int unsigned MAX_BURST      = 64,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [31:0]               src_addr,
   input  logic [MEM_ADDR_WIDTH-1:0] dst_waddr,
   input  logic [CNT_WIDTH-1:0]      word_count,
   output logic                      busy,
   output logic                      done,
   output logic                      aborted,
   output logic                      core_hold,
   input  logic                      avm_waitrequest,
   output logic [11:0]               avm_burstcount,
   output logic [31:0]               avm_address,
   output logic                      avm_read,
   input  logic [31:0]               avm_readdata,
   input  logic                      avm_readdatavalid,
   output logic                      mem_write,
   output logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
   output logic [31:0]               mem_wdata,
   output logic [3:0]                mem_be,
   output logic [31:0]               checksum
);

   localparam logic [11:0] MaxBurstLen = 12'(MAX_BURST);

   typedef enum logic [1:0] {StIdle, StReq, StRecv, StDone} state_e;

   state_e state_q, state_d;

   logic [31:0]               src_q;        // next source byte address
   logic [MEM_ADDR_WIDTH-1:0] dst_q;        // next imem word address
   logic [CNT_WIDTH-1:0]      remaining_q;  // words not yet received
   logic [11:0]               burst_left_q; // beats of the current burst still due
   logic                      busy_q;
   logic                      done_q;
   logic                      aborted_q;
   logic                      abort_pend_q; // finish draining the burst, then stop
   logic                      wr_q;         // registered imem write strobe
   logic [31:0]               wdata_q;

   logic        start_ok;
   logic        req_accept;
   logic        beat;
   logic        last_beat;
   logic        write_beat;
   logic        retire;
   logic        abort_live;
   logic [11:0] burst_len;

   // Address LSBs are forced to zero, so they are deliberately not consumed.
   logic unused_src_lsb;
   assign unused_src_lsb = ^src_addr[1:0];

   assign start_ok   = (state_q == StIdle) && start;
   assign req_accept = (state_q == StReq) && !avm_waitrequest;
   assign beat       = (state_q == StRecv) && avm_readdatavalid;
   assign last_beat  = beat && (burst_left_q == 12'd1);
   // A beat that coincides with an abort, or arrives after it, is dropped.
   assign write_beat = beat && !abort_pend_q && !abort;
   // DONE waits until the last registered write has left wr_q.
   assign retire     = (state_q == StDone) && !wr_q;
   assign abort_live = abort && ((state_q == StReq) || (state_q == StRecv));

   // The burst length is min(remaining, MAX_BURST).
   always_comb begin
      if (32'(remaining_q) > MAX_BURST) begin
         burst_len = MaxBurstLen;
      end else begin
         burst_len = 12'(remaining_q);
      end
   end

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (word_count == '0) ? StDone : StReq;
            end
         end
         StReq: begin
            // An accepted request must be drained even if abort arrives with it.
            if (!avm_waitrequest) begin
               state_d = StRecv;
            end else if (abort) begin
               state_d = StDone;
            end
         end
         StRecv: begin
            if (last_beat) begin
               if ((remaining_q == CNT_WIDTH'(1)) || abort_pend_q || abort) begin
                  state_d = StDone;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StDone: begin
            if (!wr_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      avm_read       = 1'b0;
      avm_burstcount = '0;
      avm_address    = '0;
      if (state_q == StReq) begin
         avm_read       = 1'b1;
         avm_burstcount = burst_len;
         avm_address    = src_q;
      end
      mem_write = wr_q;
      mem_waddr = dst_q;
      mem_wdata = wdata_q;
      mem_be    = {4{wr_q}};
      busy      = busy_q;
      core_hold = busy_q;
      done      = done_q;
      aborted   = aborted_q;
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         src_q        <= '0;
         dst_q        <= '0;
         remaining_q  <= '0;
         burst_left_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
      end else begin
         done_q <= retire;
         wr_q   <= write_beat;

         if (write_beat) begin
            wdata_q <= avm_readdata;
         end

         // The write in flight uses dst_q and then moves it on, wrapping naturally.
         if (wr_q) begin
            dst_q <= dst_q + MEM_ADDR_WIDTH'(1);
         end

         if (start_ok) begin
            src_q        <= {src_addr[31:2], 2'b00};
            dst_q        <= dst_waddr;
            remaining_q  <= word_count;
            busy_q       <= 1'b1;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
         end

         if (retire) begin
            busy_q <= 1'b0;
         end

         if (req_accept) begin
            burst_left_q <= burst_len;
         end

         if (beat) begin
            remaining_q  <= remaining_q - CNT_WIDTH'(1);
            burst_left_q <= burst_left_q - 12'd1;
            src_q        <= src_q + 32'd4;
         end

         if (abort_live) begin
            aborted_q <= 1'b1;
         end

         // Beats are owed only once the slave has taken the request.
         if (abort && (req_accept || (state_q == StRecv))) begin
            abort_pend_q <= 1'b1;
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] checksum_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         checksum_q <= '0;
      end else if (start_ok) begin
         checksum_q <= '0;
      end else if (wr_q) begin
         checksum_q <= checksum_q + wdata_q;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_imem_burst_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for imem_burst_loader. Stimulus pushes the expected
// requests, writes and completion status into queues; one negedge process
// models the Avalon slave and pops and compares as the DUT produces them.
module tb_imem_burst_loader;

   localparam int unsigned Aw    = 12;
   localparam int unsigned Burst = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam bit CsumEn = 1'b1;
`else
   localparam bit CsumEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          abort;
   logic [31:0]   src_addr;
   logic [Aw-1:0] dst_waddr;
   logic [15:0]   word_count;
   logic          busy;
   logic          done;
   logic          aborted;
   logic          core_hold;
   logic          avm_waitrequest = 1'b0;
   logic [11:0]   avm_burstcount;
   logic [31:0]   avm_address;
   logic          avm_read;
   logic [31:0]   avm_readdata = 32'h0;
   logic          avm_readdatavalid = 1'b0;
   logic          mem_write;
   logic [Aw-1:0] mem_waddr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic [31:0]   checksum;

   always #5 clk = ~clk;

   imem_burst_loader #(
      .MEM_ADDR_WIDTH (Aw),
      .MAX_BURST      (Burst),
      .CNT_WIDTH      (16)
   ) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start             (start),
      .abort             (abort),
      .src_addr          (src_addr),
      .dst_waddr         (dst_waddr),
      .word_count        (word_count),
      .busy              (busy),
      .done              (done),
      .aborted           (aborted),
      .core_hold         (core_hold),
      .avm_waitrequest   (avm_waitrequest),
      .avm_burstcount    (avm_burstcount),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .mem_write         (mem_write),
      .mem_waddr         (mem_waddr),
      .mem_wdata         (mem_wdata),
      .mem_be            (mem_be),
      .checksum          (checksum)
   );

   typedef struct {
      logic [Aw-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   typedef struct {
      logic [31:0] addr;
      logic [11:0] bc;
   } req_t;

   typedef struct {
      logic        ab;
      logic [31:0] csum;
      int          lat;   // -1: latency not checked
   } done_t;

   wr_t   exp_wr[$];
   req_t  exp_req[$];
   done_t exp_done[$];

   int checks   = 0;
   int failures = 0;

   // Knobs written only by the stimulus process.
   int wait_cfg = 0;
   bit stray_en = 1'b0;

   // State owned by the monitor/slave process.
   int          cyc        = 0;
   int          start_cyc  = 0;
   int          wd         = 0;
   int          wait_left  = 0;
   int          beats_left = 0;
   logic [31:0] saddr      = 32'h0;
   bit          read_prev  = 1'b0;
   bit          rst_seen   = 1'b0;
   bit          start_dly  = 1'b0;
   bit          done_prev  = 1'b0;
   bit          acc;
   wr_t         w_got;
   done_t       d_got;

   // Slave memory contents: 0x8000.. returns 1,2,3,...; elsewhere a tagged address.
   function automatic logic [31:0] data_of(input logic [31:0] a);
      if (a[31:12] == 20'h00008) return {22'b0, a[11:2]} + 32'd1;
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      checks++;
      failures++;
      $display("FAIL %s: %s (t=%0t)", name, what, $time);
   endtask

   // ------------------------------------------------ slave model + monitor
   always @(negedge clk) begin
      cyc++;
      if (!reset_n) begin
         if (rst_seen) begin
            chk("reset_ctrl", 64'({busy, done, aborted, core_hold, avm_read, mem_write, mem_be}),
                64'h0);
            chk("reset_bus", 64'({avm_burstcount, avm_address, mem_waddr}), 64'h0);
            chk("reset_data", {mem_wdata, checksum}, 64'h0);
         end
         rst_seen          = 1'b1;
         beats_left        = 0;
         wait_left         = 0;
         read_prev         = 1'b0;
         start_dly         = 1'b0;
         done_prev         = 1'b0;
         avm_waitrequest   = 1'b0;
         avm_readdatavalid = 1'b0;
         avm_readdata      = 32'h0;
      end else begin
         rst_seen = 1'b0;

         // Each new request sees wait_cfg cycles of waitrequest.
         if (avm_read && !read_prev) wait_left = wait_cfg;
         read_prev = avm_read;
         if (avm_read && wait_left > 0) begin
            avm_waitrequest = 1'b1;
            wait_left--;
         end else begin
            avm_waitrequest = 1'b0;
         end
         acc = avm_read && !avm_waitrequest;

         chk("core_hold_eq_busy", 64'(core_hold), 64'(busy));

         if (start_dly) chk("busy_rise", 64'({busy, core_hold}), 64'h3);
         start_dly = start && !busy;
         if (start && !busy) start_cyc = cyc;

         if (avm_read) begin
            chk("no_overlap", 64'(beats_left), 64'h0);
            if (exp_req.size() == 0) begin
               if (acc) fail_now("unexpected_req", $sformatf("addr %h bc %0d", avm_address,
                                                             avm_burstcount));
            end else begin
               chk(acc ? "req_accept" : "req_hold", 64'({avm_address, avm_burstcount}),
                   64'({exp_req[0].addr, exp_req[0].bc}));
               if (acc) void'(exp_req.pop_front());
            end
         end

         if (mem_write) begin
            if (exp_wr.size() == 0) begin
               fail_now("unexpected_write", $sformatf("addr %h data %h", mem_waddr, mem_wdata));
            end else begin
               w_got = exp_wr.pop_front();
               chk("write", 64'({mem_be, mem_waddr, mem_wdata}),
                   64'({4'hF, w_got.addr, w_got.data}));
            end
         end

         if (done) begin
            chk("done_width", 64'(done_prev), 64'h0);
            if (exp_done.size() == 0) begin
               fail_now("unexpected_done", "done pulse with no load expected");
            end else begin
               d_got = exp_done.pop_front();
               chk("done_status", 64'({aborted, busy, core_hold}), 64'({d_got.ab, 2'b00}));
               chk("done_checksum", 64'(checksum), 64'(d_got.csum));
               chk("beats_drained", 64'(beats_left), 64'h0);
               chk("writes_drained", 64'(exp_wr.size()), 64'h0);
               chk("reqs_drained", 64'(exp_req.size()), 64'h0);
               if (d_got.lat >= 0) chk("done_latency", 64'(cyc - start_cyc), 64'(d_got.lat));
            end
         end
         done_prev = done;

         if (exp_done.size() != 0) wd++;
         else wd = 0;
         if (wd > 3000) begin
            fail_now("timeout", "no done pulse within 3000 cycles");
            exp_done.delete();
            exp_wr.delete();
            exp_req.delete();
            wd = 0;
         end

         // Beats of an accepted burst return back to back from the next cycle.
         if (beats_left != 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = data_of(saddr);
            saddr             = saddr + 32'd4;
            beats_left--;
         end else if (stray_en && !busy) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hDEAD_BEEF;
         end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = 32'h0;
         end
         if (acc) begin
            beats_left = int'(avm_burstcount);
            saddr      = avm_address;
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic load(input logic [31:0] src, input logic [Aw-1:0] dst, input int cnt,
                       input int nwr, input bit ab, input bit do_req, input int lat);
      logic [31:0] a;
      logic [31:0] sum;
      int          rem;
      int          bc;
      wr_t         w;
      req_t        r;
      done_t       d;
      a   = {src[31:2], 2'b00};
      sum = 32'h0;
      if (do_req) begin
         rem = cnt;
         while (rem > 0) begin
            bc     = (rem > int'(Burst)) ? int'(Burst) : rem;
            r.addr = a;
            r.bc   = 12'(bc);
            exp_req.push_back(r);
            a   = a + 32'(4 * bc);
            rem = rem - bc;
         end
      end
      a = {src[31:2], 2'b00};
      for (int i = 0; i < nwr; i++) begin
         w.addr = dst + Aw'(i);
         w.data = data_of(a + 32'(4 * i));
         sum    = sum + w.data;
         exp_wr.push_back(w);
      end
      d.ab   = ab;
      d.csum = CsumEn ? sum : 32'h0;
      d.lat  = lat;
      exp_done.push_back(d);
      src_addr   = src;
      dst_waddr  = dst;
      word_count = 16'(cnt);
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         if (exp_done.size() == 0 && !busy) break;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      src_addr   = 32'h0;
      dst_waddr  = '0;
      word_count = 16'h0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single burst of 10 words.
      load(32'h0000_1000, 12'h000, 10, 10, 1'b0, 1'b1, -1);
      wait_idle();

      // 150 words split 64/64/22; a start mid-load must be ignored.
      load(32'h0000_1000, 12'h100, 150, 150, 1'b0, 1'b1, -1);
      repeat (20) @(posedge clk);
      #1;
      src_addr   = 32'h0000_9000;
      dst_waddr  = 12'h007;
      word_count = 16'd5;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle();

      // Five cycles of waitrequest on the only request.
      wait_cfg = 5;
      load(32'h0000_3000, 12'h020, 3, 3, 1'b0, 1'b1, -1);
      wait_idle();
      wait_cfg = 0;

      // Destination wrap; source LSBs are ignored.
      load(32'h0000_4002, 12'hFFE, 4, 4, 1'b0, 1'b1, -1);
      wait_idle();

      // Abort while the 3rd write is on the port: the 4th and later beats are dropped.
      load(32'h0000_5000, 12'h040, 10, 3, 1'b1, 1'b1, -1);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (mem_write && mem_waddr == 12'h042) break;
      end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      wait_idle();

      // Abort while the request is still stalled: nothing accepted, nothing written.
      wait_cfg = 1000;
      load(32'h0000_6000, 12'h000, 8, 0, 1'b1, 1'b0, -1);
      repeat (3) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      wait_idle();
      wait_cfg = 0;

      // Zero-length load with stray readdatavalid while idle.
      stray_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      load(32'h0000_7000, 12'h055, 0, 0, 1'b0, 1'b0, 2);
      wait_idle();
      stray_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Data 1,2,3,4: checksum 10 when the feature is built in.
      load(32'h0000_8000, 12'h300, 4, 4, 1'b0, 1'b1, -1);
      wait_idle();

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
